// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction memory request, holds the
// fetched word for decode, and follows redirects (misaligned target -> fault).
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] cnt_q, cnt_d;

    logic misaligned;
    logic ack_hit;

    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
    assign ack_hit    = imem_req && imem_ack;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = misaligned ? S_FAULT : S_FETCH;
            S_FETCH: if (misaligned) state_d = S_FAULT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: the only combinational output
    always_comb begin
        imem_req = 1'b0;
        if (state_q == S_FETCH) begin
            imem_req = !redirect && (!valid_q || !stall);
        end
    end

    // Datapath next-state
    always_comb begin
        fpc_d   = fpc_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    if (misaligned) fault_d = 1'b1;
                    else            fpc_d   = redirect_pc;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (misaligned) fault_d = 1'b1;
                    else            fpc_d   = redirect_pc;
                end else if (ack_hit) begin
                    instr_d = imem_rdata;
                    pc_d    = fpc_q;
                    pcp4_d  = fpc_q + 32'd4;
                    valid_d = 1'b1;
                    fpc_d   = fpc_q + 32'd4;
                    cnt_d   = cnt_q + 32'd1;
                end else if (valid_q && !stall) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q   <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
            pcp4_q  <= RESET_PC + 32'd4;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            fpc_q   <= fpc_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = fpc_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pcp4_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the instruction shown on Instr while instr_valid=0.
REQ-003 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have ports: imem_req  out  1  fetch request valid; imem_addr  out  32  fetch byte address.
REQ-006 SHALL have ports: imem_ack  in  1  memory returns imem_rdata for imem_addr this cycle; imem_rdata  in  32  instruction word.
REQ-007 SHALL have ports: stall  in  1  decode stage cannot accept an instruction this cycle.
REQ-008 SHALL have ports: redirect  in  1  taken branch or jump; redirect_pc  in  32  target address.
REQ-009 SHALL have ports: Instr  out  32  instruction to decode; PC  out  32  address of Instr; PCPlus4  out  32  PC+4.
REQ-010 SHALL have ports: instr_valid  out  1  Instr/PC hold a real instruction; fault  out  1  sticky misaligned-redirect flag; fetch_count  out  32  instructions delivered.

Function
REQ-011 SHALL hold an internal fetch_pc register and a 3-state FSM: IDLE, FETCH, FAULT.
REQ-012 IDLE SHALL be entered on reset and SHALL move to FETCH on the next rising edge; imem_req=0 in IDLE.
REQ-013 In FETCH: imem_addr=fetch_pc; imem_req = !redirect && (!instr_valid || !stall), combinational.
REQ-014 An ack SHALL count only when imem_req=1 and imem_ack=1 in the same cycle (zero-wait memory is legal).
REQ-015 On a counted ack: Instr<=imem_rdata, PC<=fetch_pc, PCPlus4<=fetch_pc+4, instr_valid<=1, fetch_pc<=fetch_pc+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000), fetch_count<=fetch_count+1 (wraps).
REQ-016 Consumption: instr_valid=1 && stall=0 at an edge; if no counted ack in that cycle, instr_valid<=0 and Instr<=NOP_INSTR.
REQ-017 instr_valid=1 && stall=1 SHALL hold Instr, PC, PCPlus4 and instr_valid unchanged; imem_req=0.
REQ-018 imem_addr SHALL stay stable while imem_req=1 and no ack; imem_req may drop only due to stall or redirect.
REQ-019 redirect=1 in FETCH SHALL have top priority: fetch_pc<=redirect_pc, instr_valid<=0, Instr<=NOP_INSTR; any imem_ack that cycle is ignored and fetch_count does not increment.
REQ-020 redirect=1 with redirect_pc[1:0]!=2'b00 SHALL move to FAULT instead: fault<=1, instr_valid<=0, Instr<=NOP_INSTR.
REQ-021 FAULT SHALL be absorbing until reset: imem_req=0, and all inputs including redirect ignored.
REQ-022 redirect in IDLE SHALL update fetch_pc (or enter FAULT if misaligned) with the same rules.
REQ-023 Instr SHALL equal NOP_INSTR whenever instr_valid=0.
REQ-024 All outputs except imem_req SHALL be registered.

Reset
REQ-025 reset=0 SHALL immediately (asynchronously) force: state=IDLE, fetch_pc=RESET_PC, PC=RESET_PC, PCPlus4=RESET_PC+4, Instr=NOP_INSTR, instr_valid=0, fault=0, fetch_count=0, imem_req=0.
REQ-026 Reset asserted mid-request SHALL abandon the request; no ack arriving during reset has any effect.
REQ-027 After release, the first request SHALL be at imem_addr=RESET_PC, one cycle after the first rising edge.

Verification
REQ-028 Release reset, imem_ack=1, stall=0, imem_rdata=0x00500093 -> edge1 FETCH; edge2 PC=0, instr_valid=1; edge3 PC=4; edge4 PC=8; fetch_count=3.
REQ-029 Stall=1 for 3 cycles with instr_valid=1 at PC=4 -> imem_req=0, PC/Instr frozen; stall=0 -> next edge PC=8.
REQ-030 imem_ack delayed 2 cycles at addr 0x8 -> imem_addr stays 0x8, instr_valid=0, Instr=0x00000013 after prior consume, loads on the ack edge.
REQ-031 redirect=1, redirect_pc=0x100, same cycle as imem_ack -> ack dropped, instr_valid=0, fetch_count unchanged, next request imem_addr=0x100.
REQ-032 redirect_pc=0x102 -> fault=1, imem_req=0 permanently; later redirect to 0x200 ignored; reset clears fault.
REQ-033 reset=0 asserted mid-cycle during an outstanding request -> all outputs reach reset values before the next edge; restart fetches from 0x0.
